multicycle_ctrl: RTL and testbench

//  Main control FSM for the multicycle MIPS core. Sequences PC, IR, register file,

---
 rtl/multicycle_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM for the multicycle MIPS core.
//
// Sequences PC, IR, register file, memory and ALU over several cycles per
// instruction. The outputs come from the registered state. Three of them also
// use the memory handshake in the current cycle: IRWrite and PCWrite in FETCH,
// and instr_done in MEMWR.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset (state -> IDLE)
//   Op           opcode from IR; only looked at in DECODE and MEMADR
//   mem_ready    memory access completes this cycle
//   PCWrite      unconditional PC load
//   PCWriteCond  PC load qualified externally by ALU Zero
//   IorD         memory address select: 0 = PC, 1 = ALUOut
//   MemRead      memory read strobe
//   MemWrite     memory write strobe
//   IRWrite      instruction register load
//   MemtoReg     write-back source: 0 = ALUOut, 1 = MDR
//   RegDst       destination register: 0 = rt, 1 = rd
//   RegWrite     register file write enable
//   ALUSrcA      ALU A: 0 = PC, 1 = reg A
//   ALUSrcB      ALU B: 00 = reg B, 01 = 4, 10 = sext(imm), 11 = sext(imm)<<2
//   ALUOP        to ALU control: 00 = R-type (funct), 01 = addu, 10 = sub
//   PCSource     next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target
//   instr_done   one-cycle pulse in an instruction's final state
//   illegal      high while in TRAP
//   state        current state, for debug
module multicycle_ctrl #(
  parameter logic [5:0] OP_R    = 6'b000000,
  parameter logic [5:0] OP_LW   = 6'b100011,
  parameter logic [5:0] OP_SW   = 6'b101011,
  parameter logic [5:0] OP_BEQ  = 6'b000100,
  parameter logic [5:0] OP_J    = 6'b000010,
  parameter logic [5:0] OP_ADDI = 6'b001000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOP,
  output logic [1:0] PCSource,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] FETCH  = 4'd1;
  localparam logic [3:0] DECODE = 4'd2;
  localparam logic [3:0] MEMADR = 4'd3;
  localparam logic [3:0] MEMRD  = 4'd4;
  localparam logic [3:0] MEMWB  = 4'd5;
  localparam logic [3:0] MEMWR  = 4'd6;
  localparam logic [3:0] REXE   = 4'd7;
  localparam logic [3:0] RWB    = 4'd8;
  localparam logic [3:0] BEQ    = 4'd9;
  localparam logic [3:0] JUMP   = 4'd10;
  localparam logic [3:0] IEXE   = 4'd11;
  localparam logic [3:0] IWB    = 4'd12;
  localparam logic [3:0] TRAP   = 4'd15;

  localparam logic [1:0] ALUOP_R    = 2'b00;
  localparam logic [1:0] ALUOP_ADDU = 2'b01;
  localparam logic [1:0] ALUOP_SUB  = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  logic [3:0] state_q, state_d;

  // State register: reset wins in every state, including stalls and TRAP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   state_d = FETCH;
      FETCH:  state_d = mem_ready ? DECODE : FETCH;
      DECODE: begin
        if (Op == OP_LW || Op == OP_SW) begin
          state_d = MEMADR;
        end else if (Op == OP_R) begin
          state_d = REXE;
        end else if (Op == OP_BEQ) begin
          state_d = BEQ;
        end else if (Op == OP_J) begin
          state_d = JUMP;
        end else if (Op == OP_ADDI) begin
          state_d = IEXE;
        end else begin
          state_d = TRAP;
        end
      end
      MEMADR: begin
        // Op is decoded again here to choose load or store. If IR changed
        // to a non-memory opcode, the FSM traps rather than guessing.
        if (Op == OP_LW) begin
          state_d = MEMRD;
        end else if (Op == OP_SW) begin
          state_d = MEMWR;
        end else begin
          state_d = TRAP;
        end
      end
      MEMRD:  state_d = mem_ready ? MEMWB : MEMRD;
      MEMWB:  state_d = FETCH;
      MEMWR:  state_d = mem_ready ? FETCH : MEMWR;
      REXE:   state_d = RWB;
      RWB:    state_d = FETCH;
      BEQ:    state_d = FETCH;
      JUMP:   state_d = FETCH;
      IEXE:   state_d = IWB;
      IWB:    state_d = FETCH;
      TRAP:   state_d = TRAP;
      default: state_d = TRAP;  // Encodings 13 and 14 are unused.
    endcase
  end

  // Output decode. Every output is 0 unless the current state sets it.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REG;
    ALUOP       = ALUOP_R;
    PCSource    = PCSRC_ALU;
    instr_done  = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      FETCH: begin
        MemRead  = 1'b1;
        IorD     = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = SRCB_FOUR;
        ALUOP    = ALUOP_ADDU;
        PCSource = PCSRC_ALU;
        // Load IR and advance the PC only when the fetch completes. This
        // keeps the PC stable across wait cycles.
        IRWrite  = mem_ready;
        PCWrite  = mem_ready;
      end
      DECODE: begin
        // Compute the branch target early so it is waiting in ALUOut.
        ALUSrcA = 1'b0;
        ALUSrcB = SRCB_BOFF;
        ALUOP   = ALUOP_ADDU;
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOP   = ALUOP_ADDU;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        RegDst     = 1'b0;
        instr_done = 1'b1;
      end
      MEMWR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
      end
      REXE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_REG;
        ALUOP   = ALUOP_R;
      end
      RWB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        MemtoReg   = 1'b0;
        instr_done = 1'b1;
      end
      BEQ: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_REG;
        ALUOP       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        instr_done  = 1'b1;
      end
      JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = PCSRC_JUMP;
        instr_done = 1'b1;
      end
      IEXE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOP   = ALUOP_ADDU;
      end
      IWB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        instr_done = 1'b1;
      end
      TRAP: begin
        illegal = 1'b1;
      end
      default: begin
        // IDLE and the unused encodings drive nothing.
      end
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl. For each cycle the bench drives the
// inputs, pushes the expected output vector onto a scoreboard queue, and at
// the falling edge pops that vector and compares it with the DUT outputs.
module tb_multicycle_ctrl;

  logic       clk;
  logic       rst_n;
  logic [5:0] Op;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, instr_done, illegal;
  logic [1:0] ALUSrcB, ALUOP, PCSource;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;
  logic [21:0] exp_q[$];

  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD = 4'd4, S_MEMWB = 4'd5, S_MEMWR = 4'd6, S_REXE = 4'd7;
  localparam logic [3:0] S_RWB = 4'd8, S_BEQ = 4'd9, S_JUMP = 4'd10, S_IEXE = 4'd11;
  localparam logic [3:0] S_IWB = 4'd12, S_TRAP = 4'd15;

  multicycle_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Op          (Op),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOP       (ALUOP),
    .PCSource    (PCSource),
    .instr_done  (instr_done),
    .illegal     (illegal),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no summary, required $finish");
    $fatal(1, "watchdog");
  end

  // Expected outputs for a state, taken from the state table. The fields are
  // packed in the same order as observed().
  function automatic logic [21:0] expv(input logic [3:0] st, input logic mr);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, done, ill;
    logic [1:0] srcb, aop, pcs;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, done, ill} = '0;
    srcb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (st)
      S_FETCH:  begin mrd = 1; srcb = 2'b01; aop = 2'b01; irw = mr; pcw = mr; end
      S_DECODE: begin srcb = 2'b11; aop = 2'b01; end
      S_MEMADR: begin srca = 1; srcb = 2'b10; aop = 2'b01; end
      S_MEMRD:  begin mrd = 1; iord = 1; end
      S_MEMWB:  begin rw = 1; m2r = 1; done = 1; end
      S_MEMWR:  begin mwr = 1; iord = 1; done = mr; end
      S_REXE:   begin srca = 1; end
      S_RWB:    begin rw = 1; rdst = 1; done = 1; end
      S_BEQ:    begin srca = 1; aop = 2'b10; pcwc = 1; pcs = 2'b01; done = 1; end
      S_JUMP:   begin pcw = 1; pcs = 2'b10; done = 1; end
      S_IEXE:   begin srca = 1; srcb = 2'b10; aop = 2'b01; end
      S_IWB:    begin rw = 1; done = 1; end
      S_TRAP:   begin ill = 1; end
      default:  begin end
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aop, pcs, done, ill, st};
  endfunction

  function automatic logic [21:0] observed();
    return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
            RegWrite, ALUSrcA, ALUSrcB, ALUOP, PCSource, instr_done, illegal, state};
  endfunction

  // One clock cycle: drive the inputs, record the expected outputs for the
  // state that is current this cycle, compare at the falling edge, then
  // advance past the next rising edge.
  task automatic step(input string tag, input logic r, input logic mr,
                      input logic [5:0] op, input logic [3:0] st);
    logic [21:0] obs, exp;
    rst_n = r; mem_ready = mr; Op = op;
    exp_q.push_back(expv(st, mr));
    @(negedge clk);
    obs = observed();
    exp = exp_q.pop_front();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h required %h (state got %0d required %0d)",
             tag, obs, exp, obs[3:0], exp[3:0]);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; Op = 6'b000000;
    repeat (2) @(posedge clk);
    #1;
    step("reset_idle", 1'b0, 1'b0, 6'h00, S_IDLE);

    // 1: R-type with zero wait states, 0 -> 1 -> 2 -> 7 -> 8 -> 1.
    step("r_idle",   1'b1, 1'b1, 6'b000000, S_IDLE);
    step("r_fetch",  1'b1, 1'b1, 6'b000000, S_FETCH);
    step("r_decode", 1'b1, 1'b1, 6'b000000, S_DECODE);
    step("r_rexe",   1'b1, 1'b1, 6'b000000, S_REXE);
    step("r_rwb",    1'b1, 1'b1, 6'b000000, S_RWB);

    // 2: lw with two FETCH waits and one MEMRD wait, 8 cycles FETCH-to-FETCH.
    step("lw_fetch_wait0", 1'b1, 1'b0, 6'b100011, S_FETCH);
    step("lw_fetch_wait1", 1'b1, 1'b0, 6'b100011, S_FETCH);
    step("lw_fetch_rdy",   1'b1, 1'b1, 6'b100011, S_FETCH);
    step("lw_decode",      1'b1, 1'b0, 6'b100011, S_DECODE);
    step("lw_memadr",      1'b1, 1'b0, 6'b100011, S_MEMADR);
    step("lw_memrd_wait",  1'b1, 1'b0, 6'b100011, S_MEMRD);
    step("lw_memrd_rdy",   1'b1, 1'b1, 6'b100011, S_MEMRD);
    step("lw_memwb",       1'b1, 1'b0, 6'b100011, S_MEMWB);

    // 3: beq.
    step("beq_fetch",  1'b1, 1'b1, 6'b000100, S_FETCH);
    step("beq_decode", 1'b1, 1'b1, 6'b000100, S_DECODE);
    step("beq_exec",   1'b1, 1'b1, 6'b000100, S_BEQ);

    // 4: addi (4 cycles) followed by j (3 cycles).
    step("addi_fetch",  1'b1, 1'b1, 6'b001000, S_FETCH);
    step("addi_decode", 1'b1, 1'b1, 6'b001000, S_DECODE);
    step("addi_iexe",   1'b1, 1'b1, 6'b111111, S_IEXE);
    step("addi_iwb",    1'b1, 1'b1, 6'b111111, S_IWB);
    step("j_fetch",     1'b1, 1'b1, 6'b000010, S_FETCH);
    step("j_decode",    1'b1, 1'b1, 6'b000010, S_DECODE);
    step("j_jump",      1'b1, 1'b1, 6'b000010, S_JUMP);

    // 5: illegal opcode traps and stays trapped until reset.
    step("trap_fetch",  1'b1, 1'b1, 6'b111111, S_FETCH);
    step("trap_decode", 1'b1, 1'b1, 6'b111111, S_DECODE);
    for (int i = 0; i < 20; i++) begin
      step("trap_hold", 1'b1, i[0], 6'(i), S_TRAP);
    end
    step("trap_rst",   1'b0, 1'b1, 6'b000000, S_TRAP);
    step("trap_to_idle", 1'b1, 1'b1, 6'b000000, S_IDLE);

    // 6: reset during a MEMWR stall; Op changes mid-stall have no effect.
    step("sw_fetch",     1'b1, 1'b1, 6'b101011, S_FETCH);
    step("sw_decode",    1'b1, 1'b1, 6'b101011, S_DECODE);
    step("sw_memadr",    1'b1, 1'b0, 6'b101011, S_MEMADR);
    step("sw_memwr_wait", 1'b1, 1'b0, 6'b000100, S_MEMWR);
    step("sw_memwr_rst", 1'b0, 1'b0, 6'b000000, S_MEMWR);
    step("sw_rst_idle",  1'b1, 1'b0, 6'b000000, S_IDLE);

    // sw that completes normally: instr_done pulses on the ready cycle.
    step("sw2_fetch",     1'b1, 1'b1, 6'b101011, S_FETCH);
    step("sw2_decode",    1'b1, 1'b1, 6'b101011, S_DECODE);
    step("sw2_memadr",    1'b1, 1'b1, 6'b101011, S_MEMADR);
    step("sw2_memwr_rdy", 1'b1, 1'b1, 6'b000000, S_MEMWR);
    step("sw2_next_fetch", 1'b1, 1'b0, 6'b000000, S_FETCH);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
